// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one fixed-latency memory
// between the instruction-fetch port and the data ld/sd port.
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);
  typedef enum logic {IDLE, WAIT} stateT;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);
  localparam logic       PORT_I   = 1'b0;
  localparam logic       PORT_D   = 1'b1;

  stateT      state;
  logic [3:0] cnt;
  logic       owner;
  logic       half;
  logic       isWr;
  logic       last;

  logic respCycle;
  logic canIssue;
  logic iElig;
  logic dElig;
  logic grantI;
  logic grantD;

  // The owner is excluded in its response cycle: it is being answered right now.
  always_comb begin
    respCycle = (state == WAIT) && (cnt == 4'd0);
    canIssue  = reset && ((state == IDLE) || respCycle);
    iElig     = canIssue && i_req && !(respCycle && (owner == PORT_I));
    dElig     = canIssue && d_req && !(respCycle && (owner == PORT_D));
    grantD    = dElig && (!iElig || (last == PORT_I));
    grantI    = iElig && !grantD;
  end

  assign i_gnt   = grantI;
  assign d_gnt   = grantD;
  assign m_en    = grantI || grantD;
  assign m_we    = grantD && d_we;
  assign m_addr  = grantD ? d_addr : (grantI ? i_addr : '0);
  assign m_wdata = grantD ? d_wdata : '0;

  assign i_rvalid = reset && respCycle && (owner == PORT_I);
  assign d_rvalid = reset && respCycle && (owner == PORT_D);
  assign i_rdata  = !i_rvalid ? 32'd0 : (half ? m_rdata[63:32] : m_rdata[31:0]);
  assign d_rdata  = (d_rvalid && !isWr) ? m_rdata : '0;
  assign busy     = reset && (state == WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      owner <= PORT_I;
      half  <= 1'b0;
      isWr  <= 1'b0;
      last  <= PORT_I;
    end else if (grantI || grantD) begin
      state <= WAIT;
      cnt   <= CNT_INIT;
      owner <= grantD ? PORT_D : PORT_I;
      half  <= grantI && i_addr[2];
      isWr  <= grantD && d_we;
      last  <= grantD ? PORT_D : PORT_I;
    end else if (state == WAIT) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at MEM_LAT=2 and
// a second instance at MEM_LAT=1 for back-to-back alternation.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expectEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [63:0] w, input logic h);
    return h ? w[63:32] : w[31:0];
  endfunction

  // Instance A: MEM_LAT = 2
  logic        rstN, iReq, iGnt, iRvalid, dReq, dWe, dGnt, dRvalid, mEn, mWe, busy;
  logic [63:0] iAddr, dAddr, dWdata, dRdata, mAddr, mWdata, mRdata;
  logic [31:0] iRdata;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) dutA (
    .clk(clk), .reset(rstN),
    .i_req(iReq), .i_addr(iAddr), .i_gnt(iGnt), .i_rvalid(iRvalid), .i_rdata(iRdata),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_gnt(dGnt), .d_rvalid(dRvalid), .d_rdata(dRdata),
    .m_en(mEn), .m_we(mWe), .m_addr(mAddr), .m_wdata(mWdata), .m_rdata(mRdata),
    .busy(busy)
  );

  // Instance B: MEM_LAT = 1
  logic        rstNB, iReqB, iGntB, iRvalidB, dReqB, dWeB, dGntB, dRvalidB, mEnB, mWeB, busyB;
  logic [63:0] iAddrB, dAddrB, dWdataB, dRdataB, mAddrB, mWdataB, mRdataB;
  logic [31:0] iRdataB;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dutB (
    .clk(clk), .reset(rstNB),
    .i_req(iReqB), .i_addr(iAddrB), .i_gnt(iGntB), .i_rvalid(iRvalidB), .i_rdata(iRdataB),
    .d_req(dReqB), .d_we(dWeB), .d_addr(dAddrB), .d_wdata(dWdataB),
    .d_gnt(dGntB), .d_rvalid(dRvalidB), .d_rdata(dRdataB),
    .m_en(mEnB), .m_we(mWeB), .m_addr(mAddrB), .m_wdata(mWdataB), .m_rdata(mRdataB),
    .busy(busyB)
  );

  // Memory models: A returns data two cycles after m_en, B one cycle after.
  logic [63:0] mem    [0:2047];
  logic [63:0] refMem [0:2047];
  logic [63:0] rdStage;

  always @(posedge clk) begin
    if (mEn && mWe) mem[mAddr[13:3]] <= mWdata;
    rdStage <= mem[mAddr[13:3]];
    mRdata  <= rdStage;
    mRdataB <= {mAddrB[31:0], ~mAddrB[31:0]};
  end

  typedef struct {
    logic [63:0] data;
    int          due;
  } expT;

  expT iQ[$];
  expT dQ[$];
  expT eI, eD;

  always @(negedge clk) begin
    if (rstN) begin
      if (iGnt) iQ.push_back('{data: {32'd0, lane(refMem[iAddr[13:3]], iAddr[2])}, due: cyc + 2});
      if (dGnt && dWe) begin
        refMem[dAddr[13:3]] = dWdata;
        dQ.push_back('{data: 64'd0, due: cyc + 2});
      end else if (dGnt) begin
        dQ.push_back('{data: refMem[dAddr[13:3]], due: cyc + 2});
      end

      if (iRvalid) begin
        expectEq("i_rv_pending", iQ.size() != 0, 1);
        if (iQ.size() != 0) begin
          eI = iQ.pop_front();
          expectEq("i_rdata", iRdata, eI.data);
          expectEq("i_rv_cycle", cyc, eI.due);
        end
      end else if (iQ.size() != 0 && iQ[0].due <= cyc) begin
        expectEq("i_rv_missing", iRvalid, 1);
        eI = iQ.pop_front();
      end

      if (dRvalid) begin
        expectEq("d_rv_pending", dQ.size() != 0, 1);
        if (dQ.size() != 0) begin
          eD = dQ.pop_front();
          expectEq("d_rdata", dRdata, eD.data);
          expectEq("d_rv_cycle", cyc, eD.due);
        end
      end else if (dQ.size() != 0 && dQ[0].due <= cyc) begin
        expectEq("d_rv_missing", dRvalid, 1);
        eD = dQ.pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) begin
      mem[k]    = 64'd0;
      refMem[k] = 64'd0;
    end
    mem[11'h200]    = 64'h11112222_33334444;
    mem[11'h201]    = 64'h55556666_77778888;
    refMem[11'h200] = 64'h11112222_33334444;
    refMem[11'h201] = 64'h55556666_77778888;

    rstN = 1'b0; iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
    rstNB = 1'b0; iReqB = 1'b0; iAddrB = '0; dReqB = 1'b0; dWeB = 1'b0; dAddrB = '0; dWdataB = '0;

    tick();
    tick();
    iReq  = 1'b1;
    iAddr = 64'h1004;
    @(negedge clk);
    expectEq("rst_ctrl", {iGnt, dGnt, iRvalid, dRvalid, mEn, mWe, busy}, 7'h0);
    expectEq("rst_maddr", mAddr, 64'd0);
    expectEq("rst_rdata", {iRdata, dRdata[31:0]} | {32'd0, mWdata[31:0]}, 64'd0);

    // Fetch straight out of reset
    tick();
    rstN = 1'b1;
    @(negedge clk);
    expectEq("f_gnt", iGnt, 1);
    expectEq("f_men", mEn, 1);
    expectEq("f_maddr", mAddr, 64'h1004);
    expectEq("f_mwe", mWe, 0);
    expectEq("f_busy0", busy, 0);
    tick();
    iReq = 1'b0;
    @(negedge clk);
    expectEq("f_wait_men", mEn, 0);
    expectEq("f_busy", busy, 1);
    @(negedge clk);
    expectEq("f_rvalid", iRvalid, 1);
    expectEq("f_rdata", iRdata, 32'h11112222);
    tick();

    // First tie: data wins, fetch issues in the data response cycle
    iReq = 1'b1; iAddr = 64'h1000;
    dReq = 1'b1; dWe = 1'b0; dAddr = 64'h1008;
    @(negedge clk);
    expectEq("tie1", {dGnt, iGnt}, 2'b10);
    tick();
    dReq = 1'b0;
    @(negedge clk);
    expectEq("tie1_hold", iGnt, 0);
    @(negedge clk);
    expectEq("tie1_b2b", {iGnt, mEn, dRvalid}, 3'b111);
    tick();
    iReq = 1'b0;
    tick();
    tick();

    // Second tie after a fetch grant goes to data again
    iReq = 1'b1; iAddr = 64'h1004;
    dReq = 1'b1; dAddr = 64'h1008;
    @(negedge clk);
    expectEq("tie2", {dGnt, iGnt}, 2'b10);
    tick();
    dReq = 1'b0;
    tick();
    tick();
    iReq = 1'b0;
    tick();
    tick();

    // Store then load back
    dReq = 1'b1; dWe = 1'b1; dAddr = 64'h2000; dWdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    expectEq("st_gnt", dGnt, 1);
    expectEq("st_mwe", mWe, 1);
    expectEq("st_maddr", mAddr, 64'h2000);
    expectEq("st_wdata", mWdata, 64'hDEADBEEF_CAFEF00D);
    tick();
    dReq = 1'b0; dWe = 1'b0; dWdata = '0;
    @(negedge clk);
    @(negedge clk);
    expectEq("st_rvalid", dRvalid, 1);
    expectEq("st_rdata", dRdata, 64'd0);
    tick();
    dReq = 1'b1; dAddr = 64'h2000;
    @(negedge clk);
    expectEq("ld_gnt", dGnt, 1);
    tick();
    dReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expectEq("ld_rdata", dRdata, 64'hDEADBEEF_CAFEF00D);
    tick();

    // Owner keeps i_req through its response cycle
    iReq = 1'b1; iAddr = 64'h1000;
    @(negedge clk);
    expectEq("hold_gnt", iGnt, 1);
    @(negedge clk);
    @(negedge clk);
    expectEq("hold_resp", {iRvalid, iGnt, mEn}, 3'b100);
    @(negedge clk);
    expectEq("hold_regnt", iGnt, 1);
    tick();
    iReq = 1'b0;
    tick();
    tick();

    // Reset in the middle of a load
    dReq = 1'b1; dWe = 1'b0; dAddr = 64'h1008;
    @(negedge clk);
    expectEq("rm_gnt", dGnt, 1);
    tick();
    dReq = 1'b0;
    rstN = 1'b0;
    dQ.delete();
    @(negedge clk);
    expectEq("rm_outs", {iGnt, dGnt, iRvalid, dRvalid, mEn, mWe, busy}, 7'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expectEq("rm_no_rv", dRvalid, 0);
    end
    tick();
    rstN = 1'b1; iReq = 1'b1; iAddr = 64'h1004;
    @(negedge clk);
    expectEq("rm_fetch_gnt", iGnt, 1);
    tick();
    iReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expectEq("rm_fetch_rdata", {iRvalid, iRdata}, {1'b1, 32'h11112222});
    repeat (3) tick();
    @(negedge clk);
    expectEq("sb_drain", iQ.size() + dQ.size(), 0);

    // MEM_LAT=1: both ports held, grants alternate every cycle
    tick();
    rstNB = 1'b1; iReqB = 1'b1; dReqB = 1'b1; iAddrB = 64'h0; dAddrB = 64'h8;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      expectEq("b_gnt", {dGntB, iGntB}, (k % 2 == 0) ? 2'b10 : 2'b01);
      expectEq("b_men", mEnB, 1);
      expectEq("b_busy", busyB, k != 0);
      expectEq("b_rvalid", {dRvalidB, iRvalidB}, (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01));
      if (k % 2 == 1) expectEq("b_drdata", dRdataB, {32'h8, ~32'h8});
      else if (k != 0) expectEq("b_irdata", iRdataB, 32'hFFFFFFFF);
      tick();
    end
    iReqB = 1'b0;
    dReqB = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
